// File: rtl/mem_resp_pipe4.sv
// Memory-side responder for the cache fill path: single-port word array with writes
// committed at issue and reads returned through a fixed-latency valid/data pipeline.
module mem_resp_pipe4 #(
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 12,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr,
    input  logic [15:0]      addr,
    input  logic [15:0]      data_in,
    output logic [15:0]      data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] rd_pending,
    output logic             busy
);

    logic [15:0]               mem [2**MEM_AW];
    logic [MEM_AW-1:0]         idx;
    logic                      rd_issue;
    logic                      wr_issue;
    logic                      retire;
    logic [LATENCY-1:0]        vld_p;
    logic [LATENCY-1:0][15:0]  dat_p;
    logic                      unused_addr;

    assign idx         = addr[MEM_AW:1];
    assign unused_addr = ^{addr[15:MEM_AW+1], addr[0]};
    assign rd_issue    = enable & ~wr;
    assign wr_issue    = enable & wr;
    assign retire      = vld_p[LATENCY-1];

    // Storage: no reset so contents survive a reset pulse; requests are ignored while in reset.
    always_ff @(posedge clk) begin
        if (wr_issue && rst_n) begin
            mem[idx] <= data_in;
        end
    end

    // Stage 1 captures array data at issue; stages 2..LATENCY shift. Idle slots carry
    // zero data so the output is zero whenever it is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p      <= '0;
            dat_p      <= '0;
            rd_pending <= '0;
        end else begin
            vld_p[0] <= rd_issue;
            dat_p[0] <= rd_issue ? mem[idx] : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                dat_p[i] <= dat_p[i-1];
            end
            case ({rd_issue, retire})
                2'b10:   rd_pending <= rd_pending + CNT_W'(1);
                2'b01:   rd_pending <= rd_pending - CNT_W'(1);
                default: rd_pending <= rd_pending;
            endcase
        end
    end

    // Output stage
    assign data_valid = vld_p[LATENCY-1];
    assign data_out   = dat_p[LATENCY-1];
    assign busy       = (rd_pending != '0);

    pending_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        rd_pending <= CNT_W'(LATENCY));

endmodule

// File: tb/tb_mem_resp_pipe4.sv
// Scoreboard bench for mem_resp_pipe4: directed requests push expected read data with
// the cycle it must appear in; a negedge monitor pops and compares each data_valid.
module tb_mem_resp_pipe4;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  rd_pending;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_resp_pipe4 #(.LATENCY(LAT), .MEM_AW(12), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .rd_pending (rd_pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) step();
    endtask

    task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = a;
        data_in = d;
        step();
        enable  = 1'b0;
    endtask

    task automatic rd_word(input logic [15:0] a, input logic [15:0] exp, input bit expect_it);
        enable = 1'b1;
        wr     = 1'b0;
        addr   = a;
        if (expect_it) q.push_back('{cyc + LAT, exp});
        step();
        enable = 1'b0;
    endtask

    // Monitor: every data_valid must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("resp_data", 32'(data_out), 32'(e.d));
                end
            end else begin
                chk("idle_data_zero", 32'(data_out), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_pending", 32'(rd_pending), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();

        // Write then read: valid exactly LAT cycles after the read issue
        wr_word(16'h0010, 16'hBEEF);
        rd_word(16'h0010, 16'hBEEF, 1'b1);
        chk("wr_rd_pending_c2", 32'(rd_pending), 32'h1);
        chk("wr_rd_busy_c2", 32'(busy), 32'h1);
        idle(3);
        chk("wr_rd_pending_c5", 32'(rd_pending), 32'h1);
        idle(1);
        chk("wr_rd_pending_c6", 32'(rd_pending), 32'h0);
        chk("wr_rd_busy_c6", 32'(busy), 32'h0);

        // Block fill: preload then 8 back-to-back reads
        for (int i = 0; i < 8; i++) wr_word(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            rd_word(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i), 1'b1);
            if (i == 3) chk("fill_pending_peak", 32'(rd_pending), 32'h4);
            if (i == 7) chk("fill_pending_steady", 32'(rd_pending), 32'h4);
        end
        idle(4);
        chk("fill_pending_drained", 32'(rd_pending), 32'h0);

        // Hazard: data captured at issue; later write visible to later read
        wr_word(16'h0020, 16'h1111);
        rd_word(16'h0020, 16'h1111, 1'b1);
        wr_word(16'h0020, 16'h2222);
        rd_word(16'h0020, 16'h2222, 1'b1);
        idle(6);

        // Aliasing: addr[0] and bits above MEM_AW ignored
        wr_word(16'h0003, 16'hA5A5);
        rd_word(16'h2002, 16'hA5A5, 1'b1);
        rd_word(16'h0002, 16'hA5A5, 1'b1);
        idle(6);

        // Idle bus with garbage on wr/addr/data_in must not write the array
        wr = 1'b1; addr = 16'h0010; data_in = 16'hFFFF;
        idle(3);
        rd_word(16'h0010, 16'hBEEF, 1'b1);
        idle(6);

        // Mid-flight reset: three reads in flight, asynchronously cleared mid-cycle
        rd_word(16'h0100, 16'h1000, 1'b0);
        rd_word(16'h0102, 16'h1001, 1'b0);
        rd_word(16'h0104, 16'h1002, 1'b0);
        chk("flight_pending", 32'(rd_pending), 32'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_data_out", 32'(data_out), 32'h0);
        chk("async_rst_valid", 32'(data_valid), 32'h0);
        chk("async_rst_pending", 32'(rd_pending), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        #1 rst_n = 1'b1;
        idle(6);
        chk("post_rst_pending", 32'(rd_pending), 32'h0);
        rd_word(16'h0104, 16'h1002, 1'b1);
        rd_word(16'h0010, 16'hBEEF, 1'b1);
        idle(6);

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
